gs_inv_butterfly: RTL and testbench

Gentleman–Sande inverse-NTT butterfly for the 28-bit NTT datapath, the inverse-direction counterpart of the forward Cooley–Tukey butterfly.
- Computes x_out = (x + y) mod q and y_out = ((x − y) · w⁻¹) mod q, where q = 2^28 − 2^16 + 1 = 268369921.
- Inverse twiddles are sequenced from a parameter table by an internal beat-driven index.
- Sits in each stage of the INTT array, consuming the outputs of the previous inverse stage.

---
 rtl/gs_inv_butterfly.sv | 147 ++++++++++++++
 tb/tb_gs_inv_butterfly.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/gs_inv_butterfly.sv
// Gentleman-Sande inverse-NTT butterfly mod q = 2^28 - 2^16 + 1; latency MULT_LAT + 2, one beat per cycle, no backpressure.
// Optional INV_BUTTERFLY_HALF_EN scales both outputs by 2^-1 mod q in the output stage.

module modular_mult #(
    parameter int LAT = 5
) (
    input  logic        clk,
    input  logic [27:0] a_i,
    input  logic [27:0] b_i,
    output logic [27:0] p_o
);
    localparam logic [28:0] Q29 = 29'd268369921;

    // Folds with 2^28 == 2^16 - 1 (mod q); three folds leave a value below 2q.
    function automatic logic [27:0] mod_q(input logic [55:0] p);
        logic [44:0] t1;
        logic [33:0] t2;
        logic [28:0] t3;
        t1 = 45'(p[27:0]) + (45'(p[55:28]) << 16) - 45'(p[55:28]);
        t2 = 34'(t1[27:0]) + (34'(t1[44:28]) << 16) - 34'(t1[44:28]);
        t3 = 29'(t2[27:0]) + (29'(t2[33:28]) << 16) - 29'(t2[33:28]);
        return (t3 >= Q29) ? 28'(t3 - Q29) : t3[27:0];
    endfunction

    generate
        if (LAT == 1) begin : g_lat1
            logic [27:0] p_q;
            always_ff @(posedge clk) p_q <= mod_q(56'(a_i) * 56'(b_i));
            assign p_o = p_q;
        end else begin : g_latn
            logic [55:0] prod_q;
            logic [27:0] red_q [LAT-1];
            always_ff @(posedge clk) begin
                prod_q   <= 56'(a_i) * 56'(b_i);
                red_q[0] <= mod_q(prod_q);
                for (int i = 1; i < LAT - 1; i++) red_q[i] <= red_q[i-1];
            end
            assign p_o = red_q[LAT-2];
        end
    endgenerate
endmodule

module gs_inv_butterfly #(
    parameter int                            START     = 0,
    parameter int                            N_FACTORS = 16,
    parameter logic [N_FACTORS-1:0][27:0]    FACTORS   = {N_FACTORS{28'd1}},
    parameter int                            MULT_LAT  = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [27:0] x_in,
    input  logic [27:0] y_in,
    output logic        out_valid,
    output logic [27:0] x_out,
    output logic [27:0] y_out
);
    localparam logic [28:0] Q29   = 29'd268369921;
    localparam int          IDX_W = (N_FACTORS > 1) ? $clog2(N_FACTORS) : 1;
    localparam int          BC_W  = (START > 0) ? $clog2(START + 1) : 1;

    logic [BC_W-1:0]  bc_q, bc_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic [28:0] s_sum, d_diff;
    logic [27:0] s_d, d_d;
    logic [27:0] s_a_q, d_a_q, w_a_q;
    logic        vld_a_q;

    logic [27:0] s_m_q   [MULT_LAT];
    logic        vld_m_q [MULT_LAT];
    logic [27:0] prod;

    logic        out_valid_q;
    logic [27:0] x_out_q, y_out_q, x_fin, y_fin;

    always_comb begin
        s_sum  = {1'b0, x_in} + {1'b0, y_in};
        d_diff = {1'b0, x_in} - {1'b0, y_in};
        s_d    = (s_sum >= Q29) ? 28'(s_sum - Q29) : s_sum[27:0];
        d_d    = d_diff[28] ? 28'(d_diff + Q29) : d_diff[27:0];
    end

    // The index only starts moving once START beats have gone by.
    always_comb begin
        bc_d  = bc_q;
        idx_d = idx_q;
        if (in_valid) begin
            if (bc_q != BC_W'(START)) begin
                bc_d = bc_q + 1'b1;
            end else begin
                idx_d = (idx_q == IDX_W'(N_FACTORS - 1)) ? '0 : idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bc_q        <= '0;
            idx_q       <= '0;
            vld_a_q     <= 1'b0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            for (int i = 0; i < MULT_LAT; i++) vld_m_q[i] <= 1'b0;
        end else begin
            bc_q        <= bc_d;
            idx_q       <= idx_d;
            vld_a_q     <= in_valid;
            vld_m_q[0]  <= vld_a_q;
            for (int i = 1; i < MULT_LAT; i++) vld_m_q[i] <= vld_m_q[i-1];
            out_valid_q <= vld_m_q[MULT_LAT-1];
            x_out_q     <= x_fin;
            y_out_q     <= y_fin;
        end
    end

    always_ff @(posedge clk) begin
        s_a_q    <= s_d;
        d_a_q    <= d_d;
        w_a_q    <= FACTORS[idx_q];
        s_m_q[0] <= s_a_q;
        for (int i = 1; i < MULT_LAT; i++) s_m_q[i] <= s_m_q[i-1];
    end

    modular_mult #(.LAT(MULT_LAT)) u_mult (
        .clk (clk),
        .a_i (d_a_q),
        .b_i (w_a_q),
        .p_o (prod)
    );

`ifdef INV_BUTTERFLY_HALF_EN
    function automatic logic [27:0] half_q(input logic [27:0] a);
        return 28'((a[0] ? (29'(a) + Q29) : 29'(a)) >> 1);
    endfunction
    assign x_fin = half_q(s_m_q[MULT_LAT-1]);
    assign y_fin = half_q(prod);
`else
    assign x_fin = s_m_q[MULT_LAT-1];
    assign y_fin = prod;
`endif

    assign out_valid = out_valid_q;
    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
endmodule

// File: tb/tb_gs_inv_butterfly.sv
// Bench for gs_inv_butterfly: a default instance (all-ones twiddles) and a
// START=2 / 4-entry instance, checked against a delay-queue arithmetic model.
module tb_gs_inv_butterfly;
    localparam int     ML = 5;
    localparam int     L  = ML + 2;
    localparam longint Q  = 268369921;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        v0 = 1'b0, v1 = 1'b0;
    logic [27:0] xi = '0, yi = '0;
    logic        ov0, ov1;
    logic [27:0] x0, y0, x1, y1;

    gs_inv_butterfly #(.MULT_LAT(ML)) u0 (
        .clk(clk), .rst(rst), .in_valid(v0), .x_in(xi), .y_in(yi),
        .out_valid(ov0), .x_out(x0), .y_out(y0)
    );

    gs_inv_butterfly #(
        .START(2), .N_FACTORS(4),
        .FACTORS({28'd4, 28'd3, 28'd2, 28'd1}), .MULT_LAT(ML)
    ) u1 (
        .clk(clk), .rst(rst), .in_valid(v1), .x_in(xi), .y_in(yi),
        .out_valid(ov1), .x_out(x1), .y_out(y1)
    );

    always #5 clk = ~clk;

    typedef struct { bit vld; longint x; longint y; } exp_t;
    typedef struct { longint x; longint y; longint ex; longint ey; } vec_t;

    exp_t   q0[$], q1[$];
    longint cap[$];
    bit     capture = 1'b0;
    int     k1 = 0;
    int     checks = 0, errors = 0;
    longint f1[4]      = '{1, 2, 3, 4};
    longint seq_exp[6] = '{7, 7, 7, 14, 21, 28};
    vec_t   tbl[6];

    function automatic longint half_m(longint a);
`ifdef INV_BUTTERFLY_HALF_EN
        return (a % 2 == 0) ? a / 2 : (a + Q) / 2;
`else
        return a;
`endif
    endfunction

    function automatic exp_t model(bit v, longint x, longint y, longint w);
        exp_t e;
        e.vld = v;
        e.x   = half_m((x + y) % Q);
        e.y   = half_m((((x - y + Q) % Q) * w) % Q);
        return e;
    endfunction

    task automatic chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic init_q();
        exp_t e;
        e = '{vld: 1'b0, x: 0, y: 0};
        q0.delete();
        q1.delete();
        for (int i = 0; i < L; i++) begin
            q0.push_back(e);
            q1.push_back(e);
        end
        k1 = 0;
    endtask

    task automatic step(bit a0, bit a1, longint x, longint y);
        exp_t e;
        longint w;
        @(negedge clk);
        e = q0.pop_front();
        chk("u0_out_valid", ov0, e.vld);
        if (e.vld) begin
            chk("u0_x_out", x0, e.x);
            chk("u0_y_out", y0, e.y);
        end
        e = q1.pop_front();
        chk("u1_out_valid", ov1, e.vld);
        if (e.vld) begin
            chk("u1_x_out", x1, e.x);
            chk("u1_y_out", y1, e.y);
        end
        if (capture && ov1) cap.push_back(y1);
        v0 = a0;
        v1 = a1;
        xi = 28'(x);
        yi = 28'(y);
        q0.push_back(model(a0, x, y, 1));
        w = f1[(k1 < 2) ? 0 : ((k1 - 2) % 4)];
        q1.push_back(model(a1, x, y, w));
        if (a1) k1++;
    endtask

    task automatic check_reset_state(string tag);
        chk({tag, "_u0_out_valid"}, ov0, 0);
        chk({tag, "_u0_x_out"}, x0, 0);
        chk({tag, "_u0_y_out"}, y0, 0);
        chk({tag, "_u1_out_valid"}, ov1, 0);
        chk({tag, "_u1_x_out"}, x1, 0);
        chk({tag, "_u1_y_out"}, y1, 0);
    endtask

    // Reset lands mid-cycle; release lands just before a negedge so the next
    // step's beat meets the first edge after release.
    task automatic do_reset();
        v0 = 1'b0;
        v1 = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_state("async_rst");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        init_q();
    endtask

    task automatic check_seq(string tag);
        for (int i = 0; i < 6; i++)
            chk({tag, "_y_out"}, (i < cap.size()) ? cap[i] : -1, half_m(seq_exp[i]));
        chk({tag, "_count"}, cap.size(), 6);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{x: 5,         y: 3,         ex: 8,         ey: 2};
        tbl[1] = '{x: 3,         y: 5,         ex: 8,         ey: 268369919};
        tbl[2] = '{x: 268369920, y: 1,         ex: 0,         ey: 268369919};
        tbl[3] = '{x: 3,         y: 2,         ex: 5,         ey: 1};
        tbl[4] = '{x: 0,         y: 0,         ex: 0,         ey: 0};
        tbl[5] = '{x: 268369920, y: 268369920, ex: 268369919, ey: 0};

        #1 check_reset_state("reset");
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        init_q();

        foreach (tbl[i]) begin
            step(1, 0, tbl[i].x, tbl[i].y);
            repeat (L) step(0, 0, 0, 0);
            chk("tbl_out_valid", ov0, 1);
            chk("tbl_x_out", x0, half_m(tbl[i].ex));
            chk("tbl_y_out", y0, half_m(tbl[i].ey));
        end

        do_reset();
        cap.delete();
        capture = 1'b1;
        repeat (6) step(0, 1, 7, 0);
        repeat (L + 1) step(0, 0, 0, 0);
        capture = 1'b0;
        check_seq("seq");

        do_reset();
        cap.delete();
        capture = 1'b1;
        repeat (3) step(0, 1, 7, 0);
        repeat (3) step(0, 0, 0, 0);
        repeat (3) step(0, 1, 7, 0);
        repeat (L + 1) step(0, 0, 0, 0);
        capture = 1'b0;
        check_seq("gap");

        for (int i = 0; i < 10; i++)
            step(1, 1, $urandom_range(0, 268369920), $urandom_range(0, 268369920));
        do_reset();
        repeat (L + 3) step(0, 0, 0, 0);
        step(0, 1, 7, 0);
        repeat (L) step(0, 0, 0, 0);
        chk("post_rst_out_valid", ov1, 1);
        chk("post_rst_y_out", y1, half_m(7));

        for (int i = 0; i < 10000; i++) begin
            longint x, y;
            x = ($urandom_range(0, 7) == 0) ? Q - 1 : longint'($urandom_range(0, 268369920));
            y = ($urandom_range(0, 7) == 0) ? Q - 1 : longint'($urandom_range(0, 268369920));
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, x, y);
        end
        repeat (L + 1) step(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
